// File: rtl/comb_pkg.sv
// Shared constants and FSM state encoding for the comb buffer line reader and writer.
package comb_pkg;

    localparam int unsigned LINE_WIDTH      = 1024;
    localparam int unsigned SAMPLE_WIDTH    = 16;
    localparam int unsigned WORDS_PER_LINE  = LINE_WIDTH / SAMPLE_WIDTH;
    localparam int unsigned LINE_ADDR_WIDTH = 10;
    localparam int unsigned WORD_SEL_WIDTH  = $clog2(WORDS_PER_LINE);
    localparam int unsigned INDEX_WIDTH     = LINE_ADDR_WIDTH + WORD_SEL_WIDTH;

    // Reader FSM states; values are fixed so legacy localparam decodes stay valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } comb_state_e;

endpackage : comb_pkg

// File: rtl/comb_word_select.sv
// Combinational extraction of one sample from a memory line; word 0 sits at the line LSBs.
module comb_word_select #(
    parameter int unsigned LINE_WIDTH   = 1024,
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned WORD_BITS    = 6
) (
    input  logic [LINE_WIDTH-1:0]          line,
    input  logic [WORD_BITS-1:0]           word,
    output logic signed [SAMPLE_WIDTH-1:0] sample_c
);

    localparam int unsigned WORDS = LINE_WIDTH / SAMPLE_WIDTH;

    logic [SAMPLE_WIDTH-1:0] words [WORDS];

    // Slice the line into an indexable word array.
    for (genvar i = 0; i < WORDS; i++) begin : g_slice
        assign words[i] = line[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    end

    // Select the requested word.
    assign sample_c = $signed(words[word]);

endmodule : comb_word_select

// File: rtl/comb_line_reader.sv
// Single-line cached sample reader for the comb delay buffer, with write snooping.
module comb_line_reader #(
    parameter int unsigned LINE_WIDTH   = comb_pkg::LINE_WIDTH,
    parameter int unsigned SAMPLE_WIDTH = comb_pkg::SAMPLE_WIDTH,
    parameter int unsigned INDEX_WIDTH  = comb_pkg::INDEX_WIDTH
) (
    input  logic                                 clk_in,
    input  logic                                 rst_n,
    input  logic                                 rd_req_valid,
    output logic                                 rd_req_ready,
    input  logic [INDEX_WIDTH-1:0]               rd_index,
    output logic signed [SAMPLE_WIDTH-1:0]       sample_out,
    output logic                                 sample_valid,
    output logic                                 mem_req,
    output logic [INDEX_WIDTH-$clog2(LINE_WIDTH/SAMPLE_WIDTH)-1:0] mem_addr,
    input  logic                                 mem_ready,
    input  logic                                 mem_rvalid,
    input  logic [LINE_WIDTH-1:0]                mem_rdata,
    input  logic                                 wr_snoop_valid,
    input  logic [INDEX_WIDTH-1:0]               wr_snoop_index,
    input  logic signed [SAMPLE_WIDTH-1:0]       wr_snoop_sample,
    input  logic                                 invalidate
);

    import comb_pkg::*;

    localparam int unsigned WORDS     = LINE_WIDTH / SAMPLE_WIDTH;
    localparam int unsigned WORD_BITS = $clog2(WORDS);
    localparam int unsigned TAG_W     = INDEX_WIDTH - WORD_BITS;

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_REQ  = 2'(REQ);
    localparam logic [1:0] ST_WAIT = 2'(WAIT);
    localparam logic [1:0] ST_OUT  = 2'(OUT);

    logic [1:0]                     state_q, state_d;
    logic [INDEX_WIDTH-1:0]         idx_q, idx_d;
    logic [TAG_W-1:0]               tag_q, tag_d;
    logic                           cache_valid_q, cache_valid_d;
    logic                           inval_pend_q, inval_pend_d;
    logic [LINE_WIDTH-1:0]          line_q, line_d;
    logic signed [SAMPLE_WIDTH-1:0] sample_d;
    logic                           sample_valid_d;
    logic                           mem_req_d;
    logic [TAG_W-1:0]               mem_addr_d;
    logic                           rd_req_ready_d;
    logic                           fill;
    logic signed [SAMPLE_WIDTH-1:0] sel_sample_c;

    logic [TAG_W-1:0]     rd_tag;
    logic [TAG_W-1:0]     fetch_tag;
    logic [TAG_W-1:0]     snoop_tag;
    logic [WORD_BITS-1:0] snoop_word;

    // Split request, pending and snoop indices into line tag and word select.
    assign rd_tag     = rd_index[INDEX_WIDTH-1:WORD_BITS];
    assign fetch_tag  = idx_q[INDEX_WIDTH-1:WORD_BITS];
    assign snoop_tag  = wr_snoop_index[INDEX_WIDTH-1:WORD_BITS];
    assign snoop_word = wr_snoop_index[WORD_BITS-1:0];

    // Word extraction from the cached line for the pending request.
    comb_word_select #(
        .LINE_WIDTH   (LINE_WIDTH),
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .WORD_BITS    (WORD_BITS)
    ) u_word_select (
        .line     (line_q),
        .word     (idx_q[WORD_BITS-1:0]),
        .sample_c (sel_sample_c)
    );

    // Next-state, cache update and output decode.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        tag_d          = tag_q;
        cache_valid_d  = cache_valid_q;
        inval_pend_d   = inval_pend_q;
        line_d         = line_q;
        sample_d       = sample_out;
        sample_valid_d = 1'b0;
        mem_req_d      = mem_req;
        mem_addr_d     = mem_addr;
        fill           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rd_req_valid) begin
                    idx_d = rd_index;
                    if (cache_valid_q && (tag_q == rd_tag)) begin
                        state_d = ST_OUT;
                    end else begin
                        state_d      = ST_REQ;
                        mem_req_d    = 1'b1;
                        mem_addr_d   = rd_tag;
                        inval_pend_d = 1'b0;
                    end
                end
            end
            ST_REQ: begin
                if (invalidate) begin
                    inval_pend_d = 1'b1;
                end
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (invalidate) begin
                    inval_pend_d = 1'b1;
                end
                if (mem_rvalid) begin
                    fill    = 1'b1;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                sample_d       = sel_sample_c;
                sample_valid_d = 1'b1;
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fill) begin
            // New line lands; a same-cycle store to it wins over the memory copy.
            line_d = mem_rdata;
            if (wr_snoop_valid && (snoop_tag == fetch_tag)) begin
                for (int i = 0; i < WORDS; i++) begin
                    if (32'(snoop_word) == i) begin
                        line_d[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = wr_snoop_sample;
                    end
                end
            end
            // An invalidate seen during the fetch leaves the line usable only for this request.
            if (invalidate || inval_pend_q) begin
                cache_valid_d = 1'b0;
            end else begin
                tag_d         = fetch_tag;
                cache_valid_d = 1'b1;
            end
        end else begin
            // Keep the cached copy coherent with the writer.
            if (wr_snoop_valid && cache_valid_q && (snoop_tag == tag_q)) begin
                for (int i = 0; i < WORDS; i++) begin
                    if (32'(snoop_word) == i) begin
                        line_d[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = wr_snoop_sample;
                    end
                end
            end
            if (invalidate) begin
                cache_valid_d = 1'b0;
            end
        end

        rd_req_ready_d = (state_d == ST_IDLE);
    end

    // State, cache and registered outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            tag_q         <= '0;
            cache_valid_q <= 1'b0;
            inval_pend_q  <= 1'b0;
            line_q        <= '0;
            sample_out    <= '0;
            sample_valid  <= 1'b0;
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            rd_req_ready  <= 1'b1;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            tag_q         <= tag_d;
            cache_valid_q <= cache_valid_d;
            inval_pend_q  <= inval_pend_d;
            line_q        <= line_d;
            sample_out    <= sample_d;
            sample_valid  <= sample_valid_d;
            mem_req       <= mem_req_d;
            mem_addr      <= mem_addr_d;
            rd_req_ready  <= rd_req_ready_d;
        end
    end

endmodule : comb_line_reader

// File: tb/tb_comb_line_reader.sv
// Directed self-checking bench for comb_line_reader.
module tb_comb_line_reader;

    logic               clk_in;
    logic               rst_n;
    logic               rd_req_valid;
    logic               rd_req_ready;
    logic [15:0]        rd_index;
    logic signed [15:0] sample_out;
    logic               sample_valid;
    logic               mem_req;
    logic [9:0]         mem_addr;
    logic               mem_ready;
    logic               mem_rvalid;
    logic [1023:0]      mem_rdata;
    logic               wr_snoop_valid;
    logic [15:0]        wr_snoop_index;
    logic signed [15:0] wr_snoop_sample;
    logic               invalidate;

    int checks = 0;
    int errors = 0;

    logic [1023:0] line0, line1, line2, line3, line_top;

    comb_line_reader dut (
        .clk_in          (clk_in),
        .rst_n           (rst_n),
        .rd_req_valid    (rd_req_valid),
        .rd_req_ready    (rd_req_ready),
        .rd_index        (rd_index),
        .sample_out      (sample_out),
        .sample_valid    (sample_valid),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ready       (mem_ready),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata),
        .wr_snoop_valid  (wr_snoop_valid),
        .wr_snoop_index  (wr_snoop_index),
        .wr_snoop_sample (wr_snoop_sample),
        .invalidate      (invalidate)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1023:0] mk_line(input logic [15:0] base);
        logic [1023:0] l;
        for (int i = 0; i < 64; i++) l[i*16 +: 16] = base + 16'(i);
        return l;
    endfunction

    // One read transaction; the memory side is driven inline with fixed latency.
    task automatic read_sample(input string tag, input logic [15:0] idx, input logic miss,
                               input logic [9:0] addr_exp, input logic [1023:0] line,
                               input int stall, input logic inv, input logic snp,
                               input logic [15:0] snp_idx, input logic [15:0] snp_val,
                               input logic [15:0] exp);
        logic [15:0] held;
        chk({tag, "_ready"}, 16'(rd_req_ready), 16'd1);
        rd_req_valid = 1'b1;
        rd_index     = idx;
        tick();
        rd_req_valid = 1'b0;
        if (miss) begin
            chk({tag, "_mem_req"}, 16'(mem_req), 16'd1);
            chk({tag, "_mem_addr"}, 16'(mem_addr), 16'(addr_exp));
            for (int s = 0; s < stall; s++) begin
                tick();
                chk({tag, "_req_held"}, 16'(mem_req), 16'd1);
                chk({tag, "_addr_held"}, 16'(mem_addr), 16'(addr_exp));
            end
            mem_ready  = 1'b1;
            invalidate = inv;
            tick();
            mem_ready  = 1'b0;
            invalidate = 1'b0;
            chk({tag, "_req_drop"}, 16'(mem_req), 16'd0);
            mem_rvalid = 1'b1;
            mem_rdata  = line;
            if (snp) begin
                wr_snoop_valid  = 1'b1;
                wr_snoop_index  = snp_idx;
                wr_snoop_sample = snp_val;
            end
            tick();
            mem_rvalid     = 1'b0;
            wr_snoop_valid = 1'b0;
        end else begin
            chk({tag, "_no_mem_req"}, 16'(mem_req), 16'd0);
        end
        chk({tag, "_sv_early"}, 16'(sample_valid), 16'd0);
        tick();
        chk({tag, "_sv"}, 16'(sample_valid), 16'd1);
        chk({tag, "_sample"}, sample_out, exp);
        held = sample_out;
        tick();
        chk({tag, "_sv_pulse"}, 16'(sample_valid), 16'd0);
        chk({tag, "_hold"}, sample_out, held);
    endtask

    initial begin
        rst_n = 1'b0;
        rd_req_valid = 1'b0; rd_index = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        wr_snoop_valid = 1'b0; wr_snoop_index = '0; wr_snoop_sample = '0;
        invalidate = 1'b0;

        line1 = mk_line(16'h1000);
        line1[3*16 +: 16] = 16'h1234;
        line0 = '0;
        line0[0 +: 16]     = 16'h8000;
        line0[63*16 +: 16] = 16'h7FFF;
        line2 = mk_line(16'h2000);
        line3 = mk_line(16'h3000);
        line_top = mk_line(16'hF000);

        tick(); tick();
        chk("rst_sample_out", sample_out, 16'h0000);
        chk("rst_sample_valid", 16'(sample_valid), 16'd0);
        chk("rst_mem_req", 16'(mem_req), 16'd0);
        chk("rst_mem_addr", 16'(mem_addr), 16'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_ready_first", 16'(rd_req_ready), 16'd1);

        // Miss then hit on line 1.
        read_sample("miss43", 16'h0043, 1'b1, 10'd1, line1, 0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h1234);
        read_sample("hit47", 16'h0047, 1'b0, 10'd0, line1, 0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h1007);

        // Snoop into the cached line.
        wr_snoop_valid = 1'b1; wr_snoop_index = 16'h0045; wr_snoop_sample = 16'hBEEF;
        tick();
        wr_snoop_valid = 1'b0;
        read_sample("snoop45", 16'h0045, 1'b0, 10'd0, line1, 0, 1'b0, 1'b0, 16'h0, 16'h0, 16'hBEEF);

        // Boundary words with sign.
        read_sample("w0", 16'h0000, 1'b1, 10'd0, line0, 0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h8000);
        chk("w0_negative", (sample_out < 0) ? 16'd1 : 16'd0, 16'd1);
        read_sample("w63", 16'h003F, 1'b0, 10'd0, line0, 0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h7FFF);
        chk("w63_positive", (sample_out > 0) ? 16'd1 : 16'd0, 16'd1);

        // Refetch line 1 under backpressure, then invalidate forces another fetch.
        read_sample("stall41", 16'h0041, 1'b1, 10'd1, line1, 5, 1'b0, 1'b0, 16'h0, 16'h0, 16'h1001);
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        read_sample("inv41", 16'h0041, 1'b1, 10'd1, line1, 0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h1001);

        // Snoop coinciding with the fill of the fetching line.
        read_sample("fillsnp85", 16'h0085, 1'b1, 10'd2, line2, 0, 1'b0, 1'b1, 16'h0085, 16'h5555, 16'h5555);
        read_sample("hit86", 16'h0086, 1'b0, 10'd0, line2, 0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h2006);

        // Invalidate during the fetch: request served, line not kept.
        read_sample("invreqC1", 16'h00C1, 1'b1, 10'd3, line3, 0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h3001);
        read_sample("againC2", 16'h00C2, 1'b1, 10'd3, line3, 0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h3002);

        // Index wrap: line 1023 and line 0 are distinct.
        read_sample("topFFFF", 16'hFFFF, 1'b1, 10'h3FF, line_top, 0, 1'b0, 1'b0, 16'h0, 16'h0, 16'hF03F);
        read_sample("wrap0", 16'h0000, 1'b1, 10'd0, line0, 0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h8000);

        // Reset while waiting for the line; late data must be ignored.
        chk("wreset_ready", 16'(rd_req_ready), 16'd1);
        rd_req_valid = 1'b1; rd_index = 16'h00C0;
        tick();
        rd_req_valid = 1'b0;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("wreset_sample_out", sample_out, 16'h0000);
        chk("wreset_mem_req", 16'(mem_req), 16'd0);
        chk("wreset_mem_addr", 16'(mem_addr), 16'd0);
        chk("wreset_sv", 16'(sample_valid), 16'd0);
        tick();
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = line3;
        tick();
        mem_rvalid = 1'b0;
        chk("late_ready", 16'(rd_req_ready), 16'd1);
        for (int k = 0; k < 3; k++) begin
            chk("late_sv", 16'(sample_valid), 16'd0);
            tick();
        end
        read_sample("post_rst47", 16'h0047, 1'b1, 10'd1, line1, 0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h1007);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_comb_line_reader
